// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
//   Write end of the datapath register file. A function-unit result on bus_D
//   is captured into a one-entry write-back stage, then committed to its
//   destination register on the following edge. Two combinational read ports
//   (A feeds MUX A, B feeds MUX B) see the pending stage through a bypass.
//
// Ports
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   DA, RW, bus_D      write request: destination, strobe, data
//   AA, BA             read addresses for ports A and B
//   reg_A, reg_B       read data for ports A and B
//   wb_pend            stage holds an uncommitted write
//   wb_dest            destination of the pending write (0 when idle)
//   wr_count           committed-write counter, wraps silently
// ---------------------------------------------------------------------------
module regfile_writeback #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int R0_ZERO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] DA,
    input  logic              RW,
    input  logic [DATA_W-1:0] bus_D,
    input  logic [ADDR_W-1:0] AA,
    input  logic [ADDR_W-1:0] BA,
    output logic [DATA_W-1:0] reg_A,
    output logic [DATA_W-1:0] reg_B,
    output logic              wb_pend,
    output logic [ADDR_W-1:0] wb_dest,
    output logic [7:0]        wr_count
);
    localparam int NREG = 1 << ADDR_W;

    typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} wb_state_t;

    wb_state_t                      r_state;
    logic [ADDR_W-1:0]              r_dest;
    logic [DATA_W-1:0]              r_data;
    logic [7:0]                     r_cnt;
    logic [NREG-1:0][DATA_W-1:0]    r_regs;

    logic                           w_capture;
    logic [DATA_W-1:0]              w_rd_a;
    logic [DATA_W-1:0]              w_rd_b;

    // A write to R0 is dropped at the door when R0 is hard-wired, so it can
    // never reach the stage, the bypass or the counter.
    assign w_capture = RW && !((R0_ZERO != 0) && (DA == '0));

    // Commit of the current stage and capture of the next request share an
    // edge, so back-to-back writes keep the stage full without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_dest  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_regs  <= '0;
        end else begin
            if (r_state == S_PEND) begin
                r_regs[r_dest] <= r_data;
                r_cnt          <= r_cnt + 8'd1;
            end
            if (w_capture) begin
                r_state <= S_PEND;
                r_dest  <= DA;
                r_data  <= bus_D;
            end else begin
                r_state <= S_IDLE;
                r_dest  <= '0;
            end
        end
    end

    // Bypass comes from the stage only; a request on the inputs this cycle
    // is not visible until it has been captured.
    always_comb begin
        w_rd_a = r_regs[AA];
        if (r_state == S_PEND && r_dest == AA) w_rd_a = r_data;
        if ((R0_ZERO != 0) && AA == '0)        w_rd_a = '0;
    end

    always_comb begin
        w_rd_b = r_regs[BA];
        if (r_state == S_PEND && r_dest == BA) w_rd_b = r_data;
        if ((R0_ZERO != 0) && BA == '0)        w_rd_b = '0;
    end

    assign reg_A    = w_rd_a;
    assign reg_B    = w_rd_b;
    assign wb_pend  = (r_state == S_PEND);
    assign wb_dest  = r_dest;
    assign wr_count = r_cnt;

endmodule

// File: tb/tb_regfile_writeback.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback
//   Two instances share all inputs: u_dut (R0 writable) and u_dz (R0 tied to
//   zero). A constant vector table covers latency, bypass, back-to-back and
//   R0 handling; hand sequences cover same-cycle non-bypass and reset during
//   a pending write; a reference model with an expected-value queue covers
//   the fill/sweep, random traffic and the counter wrap.
// ---------------------------------------------------------------------------
module tb_regfile_writeback;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] DA = '0, AA = '0, BA = '0;
    logic       RW = 1'b0;
    logic [7:0] bus_D = '0;

    logic [7:0] reg_A, reg_B, wr_count;
    logic       wb_pend;
    logic [2:0] wb_dest;
    logic [7:0] z_reg_A, z_reg_B, z_wr_count;
    logic       z_wb_pend;
    logic [2:0] z_wb_dest;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_writeback #(.DATA_W(8), .ADDR_W(3), .R0_ZERO(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .DA(DA), .RW(RW), .bus_D(bus_D),
        .AA(AA), .BA(BA), .reg_A(reg_A), .reg_B(reg_B),
        .wb_pend(wb_pend), .wb_dest(wb_dest), .wr_count(wr_count));

    regfile_writeback #(.DATA_W(8), .ADDR_W(3), .R0_ZERO(1)) u_dz (
        .clk(clk), .rst_n(rst_n), .DA(DA), .RW(RW), .bus_D(bus_D),
        .AA(AA), .BA(BA), .reg_A(z_reg_A), .reg_B(z_reg_B),
        .wb_pend(z_wb_pend), .wb_dest(z_wb_dest), .wr_count(z_wr_count));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rw; logic [2:0] da; logic [7:0] d; logic [2:0] aa; logic [2:0] ba;
        logic [7:0] ea; logic [7:0] eb; logic ep; logic [2:0] ed; logic [7:0] ec;
        logic [7:0] za; logic zp; logic [7:0] zc;
    } vec_t;
    vec_t tbl[8];

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [7:0] a; logic [7:0] b; logic [7:0] za; logic [7:0] zb;
        logic p; logic [2:0] dest; logic [7:0] cnt;
    } exp_t;
    exp_t       sb[$];
    logic [7:0] m_reg[8];
    logic       m_pend;
    logic [2:0] m_dest;
    logic [7:0] m_data;
    int         m_cnt;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_pend = 1'b0; m_dest = '0; m_data = '0; m_cnt = 0;
    endtask

    function automatic logic [7:0] m_read(input logic [2:0] a);
        if (m_pend && m_dest == a) return m_data;
        return m_reg[a];
    endfunction

    // Drive one cycle of stimulus, advance the model at the edge, push the
    // expected post-edge outputs and compare them #1 after the edge.
    task automatic step(input logic rw, input logic [2:0] da, input logic [7:0] d,
                        input logic [2:0] aa, input logic [2:0] ba);
        exp_t e, g;
        @(negedge clk);
        RW = rw; DA = da; bus_D = d; AA = aa; BA = ba;
        @(posedge clk);
        if (m_pend) begin m_reg[m_dest] = m_data; m_cnt = (m_cnt + 1) % 256; end
        if (rw) begin m_pend = 1'b1; m_dest = da; m_data = d; end
        else    begin m_pend = 1'b0; m_dest = '0; end
        e.a = m_read(aa); e.b = m_read(ba);
        e.za = (aa == 0) ? 8'h00 : e.a;
        e.zb = (ba == 0) ? 8'h00 : e.b;
        e.p = m_pend; e.dest = m_dest; e.cnt = 8'(m_cnt);
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        check("sb_reg_A", reg_A, g.a);
        check("sb_reg_B", reg_B, g.b);
        check("sb_z_reg_A", z_reg_A, g.za);
        check("sb_z_reg_B", z_reg_B, g.zb);
        check("sb_wb_pend", wb_pend, g.p);
        check("sb_wb_dest", wb_dest, g.dest);
        check("sb_wr_count", wr_count, g.cnt);
        if (aa == ba) check("sb_AA_eq_BA", reg_A, reg_B);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; RW = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        //                rw da d      aa ba  ea     eb     ep ed ec    za     zp zc
        tbl[0] = '{1'b1, 3'd5, 8'hC3, 3'd0, 3'd5, 8'h00, 8'hC3, 1'b1, 3'd5, 8'd0, 8'h00, 1'b1, 8'd0};
        tbl[1] = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd5, 8'hC3, 8'hC3, 1'b0, 3'd0, 8'd1, 8'hC3, 1'b0, 8'd1};
        tbl[2] = '{1'b1, 3'd2, 8'h11, 3'd2, 3'd5, 8'h11, 8'hC3, 1'b1, 3'd2, 8'd1, 8'h11, 1'b1, 8'd1};
        tbl[3] = '{1'b1, 3'd2, 8'h22, 3'd2, 3'd5, 8'h22, 8'hC3, 1'b1, 3'd2, 8'd2, 8'h22, 1'b1, 8'd2};
        tbl[4] = '{1'b1, 3'd2, 8'h33, 3'd2, 3'd5, 8'h33, 8'hC3, 1'b1, 3'd2, 8'd3, 8'h33, 1'b1, 8'd3};
        tbl[5] = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd5, 8'h33, 8'hC3, 1'b0, 3'd0, 8'd4, 8'h33, 1'b0, 8'd4};
        tbl[6] = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd2, 8'hFF, 8'h33, 1'b1, 3'd0, 8'd4, 8'h00, 1'b0, 8'd4};
        tbl[7] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 8'hFF, 8'hFF, 1'b0, 3'd0, 8'd5, 8'h00, 1'b0, 8'd4};

        // Reset state
        #1;
        check("rst_wb_pend", wb_pend, 1'b0);
        check("rst_wb_dest", wb_dest, 3'd0);
        check("rst_wr_count", wr_count, 8'd0);
        check("rst_reg_A", reg_A, 8'd0);
        check("rst_reg_B", reg_B, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency, bypass, back-to-back, R0 handling
        foreach (tbl[i]) begin
            @(negedge clk);
            RW = tbl[i].rw; DA = tbl[i].da; bus_D = tbl[i].d; AA = tbl[i].aa; BA = tbl[i].ba;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_reg_A", i), reg_A, tbl[i].ea);
            check($sformatf("v%0d_reg_B", i), reg_B, tbl[i].eb);
            check($sformatf("v%0d_wb_pend", i), wb_pend, tbl[i].ep);
            check($sformatf("v%0d_wb_dest", i), wb_dest, tbl[i].ed);
            check($sformatf("v%0d_wr_count", i), wr_count, tbl[i].ec);
            check($sformatf("v%0d_z_reg_A", i), z_reg_A, tbl[i].za);
            check($sformatf("v%0d_z_wb_pend", i), z_wb_pend, tbl[i].zp);
            check($sformatf("v%0d_z_wr_count", i), z_wr_count, tbl[i].zc);
        end

        // Same-cycle request is not bypassed; it appears only once captured
        @(negedge clk);
        RW = 1'b1; DA = 3'd6; bus_D = 8'h99; AA = 3'd6; BA = 3'd6;
        #1;
        check("nobypass_reg_A", reg_A, 8'h00);
        @(posedge clk); #1;
        check("bypass_reg_A", reg_A, 8'h99);
        @(negedge clk);
        RW = 1'b0;
        @(posedge clk); #1;
        check("commit_reg_A", reg_A, 8'h99);
        check("commit_wr_count", wr_count, 8'd6);

        // Reset while a write is pending: it must never commit
        @(negedge clk);
        RW = 1'b1; DA = 3'd3; bus_D = 8'h5A; AA = 3'd3; BA = 3'd5;
        @(posedge clk); #1;
        check("midrst_pend_before", wb_pend, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_wb_pend", wb_pend, 1'b0);
        check("midrst_wb_dest", wb_dest, 3'd0);
        check("midrst_wr_count", wr_count, 8'd0);
        check("midrst_reg_A", reg_A, 8'h00);
        check("midrst_reg_B", reg_B, 8'h00);
        @(negedge clk);
        RW = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_reg_A", reg_A, 8'h00);
        check("postrst_wr_count", wr_count, 8'd0);
        check("postrst_wb_pend", wb_pend, 1'b0);
        model_reset();

        // Fill all registers, then sweep every AA/BA pair
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 8'(i * 8'h11), 3'(i), 3'((i + 7) % 8));
        step(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++) step(1'b0, 3'd0, 8'h00, 3'(a), 3'(b));

        // Random traffic with bursts and gaps
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

        // Counter wrap: 256 commits from reset bring wr_count back to 0
        do_reset();
        for (int i = 0; i < 256; i++)
            step(1'b1, 3'($urandom_range(1, 7)), 8'($urandom), 3'($urandom_range(0, 7)), 3'd1);
        step(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
        check("wrap_wr_count", wr_count, 8'd0);
        check("wrap_z_wr_count", z_wr_count, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: the bench never hangs
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
